// File: rtl/pacman_pkg.sv
// Shared maze-game types: headings, turn codes, map size defaults, FSM states.
// Heading helpers (clockwise, counter-clockwise, reverse) and the turn-biased candidate order.
// Pure declarations and functions; no state.
package pacman_pkg;

  typedef enum logic [3:0] {
    DIR_NONE  = 4'd0,
    DIR_UP    = 4'd1,
    DIR_RIGHT = 4'd2,
    DIR_DOWN  = 4'd3,
    DIR_LEFT  = 4'd4
  } dir_t;

  localparam logic [3:0] TURN_LEFT     = 4'd1;
  localparam logic [3:0] TURN_STRAIGHT = 4'd2;
  localparam logic [3:0] TURN_RIGHT    = 4'd3;

  localparam int MAP_W_DEF = 28;
  localparam int MAP_H_DEF = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_QUERY,
    ST_MOVE,
    ST_STUCK
  } walk_state_t;

  function automatic dir_t turn_cw(dir_t d);
    case (d)
      DIR_UP:    return DIR_RIGHT;
      DIR_RIGHT: return DIR_DOWN;
      DIR_DOWN:  return DIR_LEFT;
      DIR_LEFT:  return DIR_UP;
      default:   return DIR_NONE;
    endcase
  endfunction

  function automatic dir_t turn_ccw(dir_t d);
    case (d)
      DIR_UP:    return DIR_LEFT;
      DIR_RIGHT: return DIR_UP;
      DIR_DOWN:  return DIR_RIGHT;
      DIR_LEFT:  return DIR_DOWN;
      default:   return DIR_NONE;
    endcase
  endfunction

  function automatic dir_t reverse(dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_RIGHT: return DIR_LEFT;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      default:   return DIR_NONE;
    endcase
  endfunction

  // Candidate heading for attempt k; reverse is always the last resort and
  // unknown turn codes fall back to the straight-first order.
  function automatic dir_t cand_dir(dir_t cur, logic [3:0] turn, logic [1:0] k);
    dir_t l;
    dir_t r;
    dir_t b;
    l = turn_ccw(cur);
    r = turn_cw(cur);
    b = reverse(cur);
    case (turn)
      TURN_LEFT: begin
        case (k)
          2'd0:    return l;
          2'd1:    return cur;
          2'd2:    return r;
          default: return b;
        endcase
      end
      TURN_RIGHT: begin
        case (k)
          2'd0:    return r;
          2'd1:    return cur;
          2'd2:    return l;
          default: return b;
        endcase
      end
      default: begin
        case (k)
          2'd0:    return cur;
          2'd1:    return l;
          2'd2:    return r;
          default: return b;
        endcase
      end
    endcase
  endfunction

endpackage

// File: rtl/ghost_walker_if.sv
// Wall-map query channel: walker raises a tile query, the map answers with ack + wall flag.
// Query coordinates are held stable by the master while the request is up.
// Master = ghost walker, slave = wall map.
interface ghost_walker_if #(
  parameter int X_W = 5,
  parameter int Y_W = 5
);
  logic           o_wall_req;
  logic [X_W-1:0] o_wall_x;
  logic [Y_W-1:0] o_wall_y;
  logic           i_wall_ack;
  logic           i_wall_is_wall;

  modport master (
    output o_wall_req, o_wall_x, o_wall_y,
    input  i_wall_ack, i_wall_is_wall
  );

  modport slave (
    input  o_wall_req, o_wall_x, o_wall_y,
    output i_wall_ack, i_wall_is_wall
  );
endinterface

// File: rtl/ghost_step_calc.sv
// Neighbour tile of (x, y) in heading dir; x wraps through the side tunnel, y does not.
// Purely combinational, zero latency.
// No handshake; out_of_bounds flags a step off the top or bottom edge.
module ghost_step_calc
  import pacman_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF,
  parameter int X_W   = 5,
  parameter int Y_W   = 5
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  dir_t           dir,
  output logic [X_W-1:0] nx,
  output logic [Y_W-1:0] ny,
  output logic           out_of_bounds
);

  // One-tile step with horizontal wrap and vertical clamp detection
  always_comb begin
    nx            = x;
    ny            = y;
    out_of_bounds = 1'b0;
    case (dir)
      DIR_UP: begin
        if (y == '0) out_of_bounds = 1'b1;
        else         ny = y - 1'b1;
      end
      DIR_DOWN: begin
        if (y == Y_W'(MAP_H - 1)) out_of_bounds = 1'b1;
        else                      ny = y + 1'b1;
      end
      DIR_LEFT:  nx = (x == '0) ? X_W'(MAP_W - 1) : x - 1'b1;
      DIR_RIGHT: nx = (x == X_W'(MAP_W - 1)) ? '0 : x + 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ghost_walker.sv
// Steps one ghost a tile per accepted move tick, trying turn-biased candidates against the wall map.
// Tick at T -> first query at T+1; ack at T+1 -> o_moved and new position at T+2; up to 4 queries.
// Queries wait indefinitely for ack; ticks arriving while busy are dropped.
module ghost_walker
  import pacman_pkg::*;
#(
  parameter int   MAP_W     = MAP_W_DEF,
  parameter int   MAP_H     = MAP_H_DEF,
  parameter int   X_W       = 5,
  parameter int   Y_W       = 5,
  parameter int   START_X   = 13,
  parameter int   START_Y   = 11,
  parameter dir_t START_DIR = DIR_LEFT
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_tick,
  input  logic           i_enable,
  input  logic [3:0]     i_random_move,
  ghost_walker_if.master wall,
  output logic [X_W-1:0] o_ghost_x,
  output logic [Y_W-1:0] o_ghost_y,
  output dir_t           o_ghost_dir,
  output logic           o_moved,
  output logic           o_stuck,
  output logic           o_busy
);

  walk_state_t    state_q, state_d;
  logic [1:0]     k_q, k_d;
  logic [3:0]     turn_q, turn_d;
  logic [X_W-1:0] x_q, wall_x_q, nx;
  logic [Y_W-1:0] y_q, wall_y_q, ny;
  dir_t           dir_q, cand;
  logic [3:0]     turn_sel;
  logic [1:0]     k_sel;
  logic           blocked, load_target, commit;

  // In IDLE the first candidate is evaluated straight from the live turn code so
  // the first query can go out in the cycle after the tick.
  always_comb begin
    turn_sel = turn_q;
    k_sel    = k_q;
    if (state_q == ST_IDLE) begin
      turn_sel = i_random_move;
      k_sel    = 2'd0;
    end
    cand = cand_dir(dir_q, turn_sel, k_sel);
  end

  ghost_step_calc #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_step (
    .x             (x_q),
    .y             (y_q),
    .dir           (cand),
    .nx            (nx),
    .ny            (ny),
    .out_of_bounds (blocked)
  );

  // Next-state logic: candidate search over up to four attempts
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    turn_d      = turn_q;
    load_target = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_tick && i_enable) begin
          turn_d = i_random_move;
          k_d    = 2'd0;
          if (blocked) begin
            k_d     = 2'd1;
            state_d = ST_PICK;
          end else begin
            load_target = 1'b1;
            state_d     = ST_QUERY;
          end
        end
      end
      ST_PICK: begin
        if (blocked) begin
          if (k_q == 2'd3) state_d = ST_STUCK;
          else             k_d = k_q + 2'd1;
        end else begin
          load_target = 1'b1;
          state_d     = ST_QUERY;
        end
      end
      ST_QUERY: begin
        if (wall.i_wall_ack) begin
          if (!wall.i_wall_is_wall) begin
            commit  = 1'b1;
            state_d = ST_MOVE;
          end else if (k_q == 2'd3) begin
            state_d = ST_STUCK;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = ST_PICK;
          end
        end
      end
      ST_MOVE:  state_d = ST_IDLE;
      ST_STUCK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state, attempt counter and latched turn code
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      turn_q  <= TURN_STRAIGHT;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      turn_q  <= turn_d;
    end
  end

  // Query coordinates are only reloaded on entry to QUERY, so they hold while req is up
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wall_x_q <= '0;
      wall_y_q <= '0;
    end else if (load_target) begin
      wall_x_q <= nx;
      wall_y_q <= ny;
    end
  end

  // Position commits on the open-tile ack so it is already visible during the o_moved cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q   <= X_W'(START_X);
      y_q   <= Y_W'(START_Y);
      dir_q <= START_DIR;
    end else if (commit) begin
      x_q   <= wall_x_q;
      y_q   <= wall_y_q;
      dir_q <= cand;
    end
  end

  assign wall.o_wall_req = (state_q == ST_QUERY);
  assign wall.o_wall_x   = wall_x_q;
  assign wall.o_wall_y   = wall_y_q;
  assign o_ghost_x       = x_q;
  assign o_ghost_y       = y_q;
  assign o_ghost_dir     = dir_q;
  assign o_moved         = (state_q == ST_MOVE);
  assign o_stuck         = (state_q == ST_STUCK);
  assign o_busy          = (state_q != ST_IDLE);

endmodule
